// File: rtl/blade_scanner_if.sv
// Control and LED-output bundle of the blade scanner.
// The bench drives it through the master modport; the scanner uses the slave modport.
interface blade_scanner_if #(
  parameter int unsigned WIDTH = 6
);
  localparam int unsigned PosW = $clog2(WIDTH);

  logic             enable;
  logic [1:0]       mode;
  logic             step_req;
  logic [WIDTH-1:0] blade;
  logic [PosW-1:0]  pos;
  logic             dir;
  logic             tick;
  logic             led;

  modport master (
    output enable, mode, step_req,
    input  blade, pos, dir, tick, led
  );

  modport slave (
    input  enable, mode, step_req,
    output blade, pos, dir, tick, led
  );
endinterface

// File: rtl/blade_scanner.sv
// Walks one lit LED across a WIDTH-bit blade, paced by a prescaler tick, and
// drives a free-running heartbeat LED.
module blade_scanner #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned DIV_BITS   = 22,
  parameter int unsigned HB_BITS    = 24,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  blade_scanner_if.slave        bus
);

  localparam int unsigned PosW = $clog2(WIDTH);
  localparam logic [PosW-1:0] PosMax = PosW'(WIDTH - 1);
  localparam logic [PosW-1:0] PosMaxM1 = PosW'(WIDTH - 2);
  localparam logic [WIDTH-1:0] OneHot0 = WIDTH'(1);
  localparam logic [WIDTH-1:0] BladeRst = (ACTIVE_LOW != 0) ? ~OneHot0 : OneHot0;

  if (WIDTH < 2) begin : gen_bad_width
    $error("blade_scanner: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    ModeBounce = 2'b00,
    ModeRotL   = 2'b01,
    ModeRotR   = 2'b10,
    ModeFreeze = 2'b11
  } mode_e;

  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [HB_BITS-1:0]  hb_q;
  logic [PosW-1:0]     pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                tick_q, tick_d;
  logic [WIDTH-1:0]    blade_q, blade_d;
  logic                adv;
  mode_e               mode;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (bus.enable) begin
      presc_d = presc_q + 1'b1;
      tick_d  = (presc_q == '1);
    end
  end

  // A tick never moves the blade in freeze; only the manual step does.
  assign adv = (mode == ModeFreeze) ? bus.step_req : tick_q;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (adv) begin
      unique case (mode)
        ModeRotL: begin
          pos_d = (pos_q == PosMax) ? '0 : pos_q + 1'b1;
          dir_d = 1'b0;
        end
        ModeRotR: begin
          pos_d = (pos_q == '0) ? PosMax : pos_q - 1'b1;
          dir_d = 1'b1;
        end
        ModeBounce, ModeFreeze: begin
          if (!dir_q) begin
            if (pos_q == PosMax) begin
              pos_d = PosMaxM1;
              dir_d = 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = PosW'(1);
              dir_d = 1'b0;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Decoding from pos_d keeps blade and pos registered on the same edge.
  always_comb begin
    blade_d = OneHot0 << pos_d;
    if (ACTIVE_LOW != 0) begin
      blade_d = ~blade_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      hb_q    <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      blade_q <= BladeRst;
    end else begin
      presc_q <= presc_d;
      hb_q    <= hb_q + 1'b1;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      blade_q <= blade_d;
    end
  end

  assign bus.blade = blade_q;
  assign bus.pos   = pos_q;
  assign bus.dir   = dir_q;
  assign bus.tick  = tick_q;
  assign bus.led   = hb_q[HB_BITS-1];

endmodule
